// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel pipeline: mode encodings, colour-bar
// palette, default 640x480@60 timing and the output delay depth.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2
    } mode_t;

    // One flag per channel, ordered {B,G,R}; index 0 is the leftmost bar.
    localparam logic [2:0] BAR_BGR [8] = '{
        3'b111,  // white
        3'b011,  // yellow
        3'b110,  // cyan
        3'b010,  // green
        3'b101,  // magenta
        3'b001,  // red
        3'b100,  // blue
        3'b000   // black
    };

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Clocks from address issue to the registered video outputs.
    function automatic int pipe_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer read bus: address and strobe out, pixel data back.
interface vga_pixel_pipe_if #(
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 8
);
    logic [ADDR_W-1:0]    oADDR;
    logic                 oRD_EN;
    logic [3*COLOR_W-1:0] iPIX;

    modport master (output oADDR, output oRD_EN, input iPIX);
    modport slave  (input oADDR, input oRD_EN, output iPIX);
endinterface

// File: rtl/vga_timing_core.sv
// Stage-0 raster timing: h/v counters, run flag and the per-pixel flags
// (active, sync levels, line/frame strobes) registered alongside the counters.
module vga_timing_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          iVGA_CLK,
    input  logic          iRST,
    input  logic          iEN,
    output logic          bound,
    output logic [XW-1:0] h_p0,
    output logic [YW-1:0] v_p0,
    output logic          act_p0,
    output logic          hs_p0,
    output logic          vs_p0,
    output logic          fs_p0,
    output logic          ls_p0
);

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

    logic          run_p0;
    logic [XW-1:0] h_nxt;
    logic [YW-1:0] v_nxt;
    logic          run_nxt;

    // Next raster position; the frame boundary (idle or last pixel) is where
    // the run request is honoured and the raster returns to the origin.
    always_comb begin
        bound   = !run_p0 || (h_p0 == H_LAST && v_p0 == V_LAST);
        h_nxt   = h_p0;
        v_nxt   = v_p0;
        run_nxt = run_p0;
        if (bound) begin
            h_nxt   = '0;
            v_nxt   = '0;
            run_nxt = iEN;
        end else if (h_p0 == H_LAST) begin
            h_nxt = '0;
            v_nxt = v_p0 + 1'b1;
        end else begin
            h_nxt = h_p0 + 1'b1;
        end
    end

    // Stage 0: counters and the flags describing the pixel they point at.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            run_p0 <= 1'b0;
            h_p0   <= '0;
            v_p0   <= '0;
            act_p0 <= 1'b0;
            hs_p0  <= ~HS_POL;
            vs_p0  <= ~VS_POL;
            fs_p0  <= 1'b0;
            ls_p0  <= 1'b0;
        end else begin
            run_p0 <= run_nxt;
            h_p0   <= h_nxt;
            v_p0   <= v_nxt;
            act_p0 <= run_nxt && (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
            hs_p0  <= (run_nxt && int'(h_nxt) >= H_ACTIVE + H_FP
                               && int'(h_nxt) <  H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
            vs_p0  <= (run_nxt && int'(v_nxt) >= V_ACTIVE + V_FP
                               && int'(v_nxt) <  V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
            fs_p0  <= run_nxt && (h_nxt == '0) && (v_nxt == '0);
            ls_p0  <= run_nxt && (h_nxt == '0);
        end
    end

endmodule

// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipeline: raster timing, linear framebuffer addressing, a
// latency-matched delay line for sync/blank/coordinates and the colour mux.
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 2,
    parameter int COLOR_W  = 8,
    localparam int XW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int YW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST,
    input  logic                 iEN,
    input  logic [1:0]           iMODE,
    input  logic [3*COLOR_W-1:0] iSOLID,
    vga_pixel_pipe_if.master     mem,
    output logic                 oHS,
    output logic                 oVS,
    output logic                 oBLANK_n,
    output logic [COLOR_W-1:0]   oB,
    output logic [COLOR_W-1:0]   oG,
    output logic [COLOR_W-1:0]   oR,
    output logic [XW-1:0]        oX,
    output logic [YW-1:0]        oY,
    output logic                 oFRAME_START,
    output logic                 oLINE_START
);

    localparam int DLY = pipe_depth(RD_LAT);

    logic                 bound;
    logic [XW-1:0]        h_p0;
    logic [YW-1:0]        v_p0;
    logic                 act_p0, hs_p0, vs_p0, fs_p0, ls_p0;
    logic [ADDR_W-1:0]    addr_p0;
    mode_t                mode_q;
    logic [3*COLOR_W-1:0] solid_q;

    logic                 act_pn [1:DLY-1];
    logic                 hs_pn  [1:DLY-1];
    logic                 vs_pn  [1:DLY-1];
    logic                 fs_pn  [1:DLY-1];
    logic                 ls_pn  [1:DLY-1];
    logic [XW-1:0]        x_pn   [1:DLY-1];
    logic [YW-1:0]        y_pn   [1:DLY-1];

    function automatic logic [3*COLOR_W-1:0] bar_rgb(input logic [XW-1:0] x);
        logic [2:0] idx;
        logic [2:0] f;
        idx = 3'd0;
        for (int k = 1; k < 8; k++)
            if (x >= XW'((k * H_ACTIVE) / 8)) idx = 3'(k);
        f = BAR_BGR[idx];
        return {{COLOR_W{f[2]}}, {COLOR_W{f[1]}}, {COLOR_W{f[0]}}};
    endfunction

    function automatic logic [3*COLOR_W-1:0] pick_rgb(
        input logic                 act,
        input mode_t                mode,
        input logic [XW-1:0]        x,
        input logic [3*COLOR_W-1:0] pix,
        input logic [3*COLOR_W-1:0] solid
    );
        if (!act) return '0;
        case (mode)
            MODE_BARS:  return bar_rgb(x);
            MODE_SOLID: return solid;
            default:    return pix;
        endcase
    endfunction

    vga_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .iVGA_CLK(iVGA_CLK),
        .iRST    (iRST),
        .iEN     (iEN),
        .bound   (bound),
        .h_p0    (h_p0),
        .v_p0    (v_p0),
        .act_p0  (act_p0),
        .hs_p0   (hs_p0),
        .vs_p0   (vs_p0),
        .fs_p0   (fs_p0),
        .ls_p0   (ls_p0)
    );

    assign mem.oADDR  = addr_p0;
    assign mem.oRD_EN = act_p0;

    // Mode and solid colour change only when a new frame is about to begin.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            mode_q  <= MODE_FB;
            solid_q <= '0;
        end else if (bound && iEN) begin
            case (iMODE)
                2'd1:    mode_q <= MODE_BARS;
                2'd2:    mode_q <= MODE_SOLID;
                default: mode_q <= MODE_FB;
            endcase
            solid_q <= iSOLID;
        end
    end

    // Stage 0: running address, zero at the frame origin, bumped after each
    // active pixel so it tracks v*H_ACTIVE+h without a multiplier.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            addr_p0 <= '0;
        end else if (bound) begin
            addr_p0 <= '0;
        end else begin
            addr_p0 <= addr_p0 + ADDR_W'(act_p0);
        end
    end

    // Stages 1..RD_LAT: carry timing alongside the outstanding memory read.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 1; i < DLY; i++) begin
                act_pn[i] <= 1'b0;
                hs_pn[i]  <= ~HS_POL;
                vs_pn[i]  <= ~VS_POL;
                fs_pn[i]  <= 1'b0;
                ls_pn[i]  <= 1'b0;
                x_pn[i]   <= '0;
                y_pn[i]   <= '0;
            end
        end else begin
            act_pn[1] <= act_p0;
            hs_pn[1]  <= hs_p0;
            vs_pn[1]  <= vs_p0;
            fs_pn[1]  <= fs_p0;
            ls_pn[1]  <= ls_p0;
            x_pn[1]   <= h_p0;
            y_pn[1]   <= v_p0;
            for (int i = 2; i < DLY; i++) begin
                act_pn[i] <= act_pn[i-1];
                hs_pn[i]  <= hs_pn[i-1];
                vs_pn[i]  <= vs_pn[i-1];
                fs_pn[i]  <= fs_pn[i-1];
                ls_pn[i]  <= ls_pn[i-1];
                x_pn[i]   <= x_pn[i-1];
                y_pn[i]   <= y_pn[i-1];
            end
        end
    end

    // Output stage: iPIX now belongs to the pixel at the end of the delay line.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            oHS          <= ~HS_POL;
            oVS          <= ~VS_POL;
            oBLANK_n     <= 1'b0;
            oFRAME_START <= 1'b0;
            oLINE_START  <= 1'b0;
            oX           <= '0;
            oY           <= '0;
            {oB, oG, oR} <= '0;
        end else begin
            oHS          <= hs_pn[DLY-1];
            oVS          <= vs_pn[DLY-1];
            oBLANK_n     <= act_pn[DLY-1];
            oFRAME_START <= fs_pn[DLY-1];
            oLINE_START  <= ls_pn[DLY-1];
            oX           <= x_pn[DLY-1];
            oY           <= y_pn[DLY-1];
            {oB, oG, oR} <= pick_rgb(act_pn[DLY-1], mode_q, x_pn[DLY-1], mem.iPIX, solid_q);
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe on a 14x7 raster with RD_LAT=2: a frame-position
// reference model feeds expected outputs into queues that a monitor drains.
module tb_vga_pixel_pipe;

    localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int LAT = 2;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        fs;
        logic        ls;
        logic [3:0]  x;
        logic [2:0]  y;
        logic [23:0] rgb;
    } vid_t;

    logic        clk;
    logic        iRST, iEN;
    logic [1:0]  iMODE;
    logic [23:0] iSOLID;
    logic        oHS, oVS, oBLANK_n, oFRAME_START, oLINE_START;
    logic [7:0]  oB, oG, oR;
    logic [3:0]  oX;
    logic [2:0]  oY;

    vga_pixel_pipe_if #(.ADDR_W(19), .COLOR_W(8)) mem_if ();

    vga_pixel_pipe #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(19), .RD_LAT(LAT), .COLOR_W(8)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST        (iRST),
        .iEN         (iEN),
        .iMODE       (iMODE),
        .iSOLID      (iSOLID),
        .mem         (mem_if),
        .oHS         (oHS),
        .oVS         (oVS),
        .oBLANK_n    (oBLANK_n),
        .oB          (oB),
        .oG          (oG),
        .oR          (oR),
        .oX          (oX),
        .oY          (oY),
        .oFRAME_START(oFRAME_START),
        .oLINE_START (oLINE_START)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the address as data, LAT clocks after the read strobe.
    logic [23:0] mpipe0, mpipe1;
    always @(posedge clk) begin
        mpipe0 <= mem_if.oRD_EN ? 24'(mem_if.oADDR) : 24'hDEAD00;
        mpipe1 <= mpipe0;
    end
    assign mem_if.iPIX = mpipe1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit started  = 0;

    vid_t        vq[$];
    logic [18:0] aq[$];

    // Reference model state: position within the frame, not h/v counters.
    bit          m_run = 0;
    int          m_t = 0;
    int          m_mode = 0;
    logic [23:0] m_solid = '0;
    vid_t        dly[3];

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                         24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

    function automatic vid_t idle_rec();
        vid_t r;
        r = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        return r;
    endfunction

    task automatic step_model();
        vid_t out, s0;
        int h, v;
        bit act;
        if (iRST) begin
            m_run = 0; m_t = 0; m_mode = 0; m_solid = '0;
            for (int i = 0; i < 3; i++) dly[i] = idle_rec();
            out = idle_rec();
            act = 0; h = 0; v = 0;
        end else begin
            if (!m_run || m_t == FRAME - 1) begin
                m_run = iEN;
                m_t = 0;
                if (iEN) begin
                    m_mode  = (iMODE == 2'd3) ? 0 : int'(iMODE);
                    m_solid = iSOLID;
                end
            end else begin
                m_t++;
            end
            h = m_t % HT;
            v = m_t / HT;
            act = m_run && h < HA && v < VA;
            s0 = idle_rec();
            if (m_run) begin
                s0.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
                s0.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
                s0.x  = 4'(h);
                s0.y  = 3'(v);
                s0.fs = (m_t == 0);
                s0.ls = (h == 0);
            end
            s0.blank_n = act;
            if (act) begin
                case (m_mode)
                    1:       s0.rgb = BARS[(h * 8) / HA];
                    2:       s0.rgb = m_solid;
                    default: s0.rgb = 24'(v * HA + h);
                endcase
            end
            out = dly[2];
            dly[2] = dly[1];
            dly[1] = dly[0];
            dly[0] = s0;
        end
        vq.push_back(out);
        if (act) aq.push_back(19'(v * HA + h));
        started = 1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            step_model();
            cyc++;
            #1;
        end
    endtask

    // Monitor: video every clock, address whenever a read is presented.
    initial begin
        vid_t got, want;
        logic [18:0] want_a;
        forever begin
            @(negedge clk);
            if (started) begin
                got.hs = oHS; got.vs = oVS; got.blank_n = oBLANK_n;
                got.fs = oFRAME_START; got.ls = oLINE_START;
                got.x = oX; got.y = oY; got.rgb = {oB, oG, oR};
                n_checks++;
                if (vq.size() == 0) begin
                    n_fail++;
                    $display("FAIL video_queue cyc=%0d: no expected entry", cyc);
                end else begin
                    want = vq.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL video cyc=%0d got hs=%b vs=%b bl=%b fs=%b ls=%b x=%0d y=%0d rgb=%06h want hs=%b vs=%b bl=%b fs=%b ls=%b x=%0d y=%0d rgb=%06h",
                                 cyc, got.hs, got.vs, got.blank_n, got.fs, got.ls, got.x, got.y, got.rgb,
                                 want.hs, want.vs, want.blank_n, want.fs, want.ls, want.x, want.y, want.rgb);
                    end
                end
                if (mem_if.oRD_EN === 1'b1) begin
                    n_checks++;
                    if (aq.size() == 0) begin
                        n_fail++;
                        $display("FAIL stray_read cyc=%0d addr=%0d expected no read", cyc, mem_if.oADDR);
                    end else begin
                        want_a = aq.pop_front();
                        if (mem_if.oADDR !== want_a) begin
                            n_fail++;
                            $display("FAIL addr cyc=%0d got=%0d want=%0d", cyc, mem_if.oADDR, want_a);
                        end
                    end
                end
            end
        end
    end

    initial begin
        iRST = 1'b1; iEN = 1'b0; iMODE = 2'd0; iSOLID = '0;
        run(3);
        iRST = 1'b0;
        run(5);
        iEN = 1'b1;
        run(2 * FRAME + 30);
        iMODE = 2'd1;
        run(2 * FRAME);
        iMODE = 2'd2; iSOLID = 24'h123456;
        run(2 * FRAME);
        iMODE = 2'd3;
        run(FRAME + 10);
        iEN = 1'b0;
        run(2 * FRAME);
        iEN = 1'b1; iMODE = 2'd0;
        run(FRAME + 20);
        iRST = 1'b1;
        run(1);
        iRST = 1'b0;
        run(2 * FRAME);
        for (int i = 0; i < 3000; i++) begin
            iRST = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 199) == 0) iEN = !iEN;
            if ($urandom_range(0, 99) == 0) begin
                iMODE  = 2'($urandom_range(0, 3));
                iSOLID = 24'($urandom);
            end
            run(1);
        end
        iRST = 1'b0;
        run(10);
        @(negedge clk);
        #1;
        n_checks++;
        if (aq.size() != 0) begin
            n_fail++;
            $display("FAIL reads_outstanding got=%0d want=0", aq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pixel_pipe.md
Name: vga_pixel_pipe

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates H/V timing with configurable porches, sync widths and polarities.
- Drives a linear framebuffer read address and aligns the returned pixel data with sync and blank through a latency-matched pipeline.
- Adds frame-synchronous test-pattern modes, pixel coordinate outputs, frame/line strobes and a frame-boundary enable; sits between pixel memory and the DAC/ADV pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, asserted level of oHS
VS_POL, 0, asserted level of oVS
ADDR_W, 19, framebuffer address width
RD_LAT, 2, memory read latency in clocks, from oRD_EN to iPIX valid (>=1)
COLOR_W, 8, bits per colour channel

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
iRST  in  1  synchronous, active-high reset
iEN  in  1  run request; sampled only at frame boundary
iMODE  in  2  0=framebuffer, 1=colour bars, 2=solid, 3=reserved (treated as 0); latched at frame boundary
iSOLID  in  3*COLOR_W  solid colour {B,G,R}; latched with iMODE
oADDR  out  ADDR_W  framebuffer read address
oRD_EN  out  1  read strobe, high for active pixels
iPIX  in  3*COLOR_W  read data {B,G,R}, valid RD_LAT clocks after oRD_EN
oHS  out  1  horizontal sync
oVS  out  1  vertical sync
oBLANK_n  out  1  high during active video
oB, oG, oR  out  COLOR_W each  pixel colour
oX  out  clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  horizontal position
oY  out  clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  vertical position
oFRAME_START  out  1  one-clock pulse at x=0, y=0
oLINE_START  out  1  one-clock pulse at x=0 of every line

Behaviour:
- Reset values:
  - oHS=~HS_POL, oVS=~VS_POL.
  - oBLANK_n, oRD_EN, oADDR, RGB, oX, oY and both strobes = 0.
  - Latched mode = 0; running flag = 0.
  - All counters and pipeline stages = 0.
- Stage-0 counters:
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; h wraps H_TOTAL-1 -> 0.
  - v increments on h wrap and wraps V_TOTAL-1 -> 0.
  - Active-first order: active when h<H_ACTIVE and v<V_ACTIVE.
  - HS asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; VS uses the same rule on v, for whole lines.
- Address generation:
  - oADDR cleared at h=0, v=0; incremented after each active pixel, so addr = v*H_ACTIVE + h.
  - oRD_EN equals active at stage 0; oADDR/oRD_EN are stage-0 registered outputs.
  - No multiplier.
- Pipeline alignment:
  - oHS, oVS, oBLANK_n, oX, oY, strobes and RGB are delayed RD_LAT+1 clocks relative to oADDR/oRD_EN.
  - At the output stage, iPIX is captured for the same pixel.
- Colour selection at the output stage:
  - Blanked: RGB=0.
  - Mode 0: iPIX.
  - Mode 1: 8 equal bars across H_ACTIVE; boundaries are constants k*H_ACTIVE/8. Order: white, yellow, cyan, green, magenta, red, blue, black; channel values all-ones/zero.
  - Mode 2: latched iSOLID.
- Frame boundary (stage-0 h=0, v=0, or idle):
  - iEN, iMODE and iSOLID are sampled here; mid-frame changes are ignored.
  - Idle with iEN=1: counters start at h=0, v=0 on the next clock.
  - Running with iEN=0 at the boundary: stop at the end of the current frame.
  - Pipeline drains, then outputs hold their reset values.
- iRST has priority over everything. Mid-frame reset returns all outputs to reset values on the next clock; timing restarts only when iEN is seen.

Decomposition:
- Package vga_pkg:
  - Mode encodings (MODE_FB, MODE_BARS, MODE_SOLID).
  - 8-entry colour-bar palette.
  - Default 640x480@60 timing constants.
  - Delay-depth function (RD_LAT+1).
- Sub-module vga_timing_core: h/v counters, active/HS/VS flags at stage 0, run flag.
- Top: address generator, mode latch, delay pipeline, colour mux.

Test Plan:
All tests use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (14x7 = 98 clocks/frame) and RD_LAT=2.
1. Addressing: iRST then iEN=1 -> oRD_EN high 8 clocks per line, oADDR 0..7, 8..15, ... 31; oADDR back to 0 exactly 98 clocks after first 0.
2. Sync timing: oHS=0 for exactly 2 clocks, starting 13 clocks after oADDR=0 (h=10, +3 delay); oVS=0 for 14 clocks during line 5; both high otherwise.
3. Data alignment: memory model returns iPIX=addr RD_LAT clocks after oRD_EN, mode 0 -> output with oX=3, oY=1 gives oR=11, oBLANK_n=1; blanked outputs give RGB=0.
4. Mode latch: iMODE=1 raised at line 2 -> current frame still shows iPIX. Next frame: x=0 FFFFFF, x=1 yellow, x=7 000000. Then iMODE=2, iSOLID=123456 -> applies from the following oFRAME_START.
5. Enable: iEN dropped at line 2 -> frame completes through v=6, h=13, then idle outputs. iEN re-raised -> oFRAME_START and oADDR=0 restart cleanly.
6. Reset: iRST pulsed mid-line 1 -> next clock all outputs at reset values and mode=0; no strobes until iEN restarts.
